// File: rtl/lcd_msg_loader_if.sv
// Byte-stream input and character-memory write port of the LCD message loader.
// The loader takes the slave side; the upstream feeder or testbench takes the master side.
interface lcd_msg_loader_if #(
  parameter int ADDR_W = 6
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [8:0]        wr_data;
  logic              msg_done;
  logic              overflow;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, wr_en, wr_addr, wr_data, msg_done, overflow
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, wr_en, wr_addr, wr_data, msg_done, overflow
  );
endinterface

// File: rtl/lcd_msg_loader.sv
// Writes each ASCII message into the LCD character memory as init header, characters, terminator.
// Define LCD_LOADER_LINEWRAP_EN to wrap to line 2 after LINE_LEN printable characters.
module lcd_msg_loader #(
  parameter int         ADDR_W   = 6,
  parameter logic [8:0] END_CODE = 9'h000,
  parameter int         LINE_LEN = 16
) (
  input logic             clk,
  input logic             rst,
  lcd_msg_loader_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for the first byte of a message (byte not consumed)
  // HDR   | writing the four display-init commands
  // DATA  | accepting bytes, writing characters and line-2 commands
  // TERM  | writing the terminator entry
  // DONE  | pulsing msg_done, rewinding the address
  typedef enum logic [2:0] {IDLE, HDR, DATA, TERM, DONE} state_e;

`ifdef LCD_LOADER_LINEWRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif
  localparam int                COL_W     = $clog2(LINE_LEN + 1);
  localparam logic [ADDR_W-1:0] TERM_ADDR = '1;
  localparam logic [8:0]        LINE2_CMD = 9'h0C0;

  state_e            state_q;
  logic [1:0]        hdr_cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              line2_q;
  logic [COL_W-1:0]  col_q;
  logic              pend_q;
  logic              pend_last_q;
  logic [7:0]        pend_char_q;
  logic              wr_en_q;
  logic              msg_done_q;
  logic              ovf_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [8:0]        wr_data_q;

  logic       full, is_nl, col_full, accept;
  logic       need_wr, drop, start_pend;
  logic [8:0] need_val;

  // The last address is kept free so the terminator always fits.
  assign full     = (addr_q == TERM_ADDR);
  assign is_nl    = (bus.in_data == 8'h0A);
  assign col_full = WRAP_EN && (col_q == COL_W'(LINE_LEN));
  assign accept   = (state_q == DATA) && !pend_q && bus.in_valid;

  always_comb begin
    need_wr    = 1'b0;
    need_val   = 9'h000;
    drop       = 1'b0;
    start_pend = 1'b0;
    if (state_q == HDR) begin
      need_wr = 1'b1;
      case (hdr_cnt_q)
        2'd0:    need_val = 9'h038;
        2'd1:    need_val = 9'h00C;
        2'd2:    need_val = 9'h001;
        default: need_val = 9'h006;
      endcase
    end else if (state_q == DATA && pend_q) begin
      need_wr  = 1'b1;
      need_val = {1'b1, pend_char_q};
    end else if (accept) begin
      if (is_nl) begin
        need_wr  = !line2_q;
        need_val = LINE2_CMD;
      end else if (col_full && line2_q) begin
        drop = 1'b1;
      end else if (col_full) begin
        need_wr    = 1'b1;
        need_val   = LINE2_CMD;
        start_pend = !full;
      end else begin
        need_wr  = 1'b1;
        need_val = {1'b1, bus.in_data};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hdr_cnt_q   <= '0;
      addr_q      <= '0;
      line2_q     <= 1'b0;
      col_q       <= '0;
      pend_q      <= 1'b0;
      pend_last_q <= 1'b0;
      pend_char_q <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      msg_done_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      wr_en_q    <= 1'b0;
      msg_done_q <= 1'b0;
      if (need_wr && !full) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= addr_q;
        wr_data_q <= need_val;
        addr_q    <= addr_q + 1'b1;
      end
      if ((need_wr && full) || drop) ovf_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            ovf_q     <= 1'b0;
            addr_q    <= '0;
            hdr_cnt_q <= '0;
            line2_q   <= 1'b0;
            col_q     <= '0;
            pend_q    <= 1'b0;
            state_q   <= HDR;
          end
        end
        HDR: begin
          hdr_cnt_q <= hdr_cnt_q + 1'b1;
          if (hdr_cnt_q == 2'd3) state_q <= DATA;
        end
        DATA: begin
          if (pend_q) begin
            pend_q <= 1'b0;
            if (pend_last_q) state_q <= TERM;
          end else if (accept) begin
            if (is_nl) begin
              line2_q <= 1'b1;
              col_q   <= '0;
            end else if (col_full && !line2_q) begin
              // Wrap: the line-2 command goes out now, the character on the next cycle.
              line2_q     <= 1'b1;
              col_q       <= COL_W'(1);
              pend_q      <= start_pend;
              pend_char_q <= bus.in_data;
              pend_last_q <= bus.in_last;
            end else if (!col_full && !full) begin
              col_q <= col_q + 1'b1;
            end
            if (bus.in_last && !start_pend) state_q <= TERM;
          end
        end
        TERM: begin
          wr_en_q   <= 1'b1;
          wr_addr_q <= addr_q;
          wr_data_q <= END_CODE;
          state_q   <= DONE;
        end
        DONE: begin
          msg_done_q <= 1'b1;
          addr_q     <= '0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready = (state_q == DATA) && !pend_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.msg_done = msg_done_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_lcd_msg_loader.sv
// Bench for lcd_msg_loader: directed table, hand sequences and random messages checked
// against a list-building model of the memory image.
module tb_lcd_msg_loader;
  localparam int ADDR_W   = 6;
  localparam int DEPTH    = 1 << ADDR_W;
  localparam int LINE_LEN = 16;
`ifdef LCD_LOADER_LINEWRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  typedef bit [7:0] bq_t[$];
  typedef struct {int a; int d; int c;} rec_t;
  typedef struct {string name; string text; int term_addr; int ovf; int stalls;} vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_msg_loader_if #(.ADDR_W(ADDR_W)) bus ();
  lcd_msg_loader #(.ADDR_W(ADDR_W), .END_CODE(9'h000), .LINE_LEN(LINE_LEN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  rec_t got[$];
  int   exp_d[$];
  bit   exp_ovf;

  // Monitor: one sample per cycle, 1 time unit after the rising edge.
  initial forever begin
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    if (bus.wr_en === 1'b1) got.push_back('{int'(bus.wr_addr), int'(bus.wr_data), cyc});
    if (bus.msg_done === 1'b1) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bq_t s2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  function automatic string rep(input string c, input int n);
    string r = "";
    for (int i = 0; i < n; i++) r = {r, c};
    return r;
  endfunction

  // Memory image: entry index is the address; anything past DEPTH-2 is lost.
  function automatic void model(input bq_t m);
    int ent[$];
    bit line2 = 1'b0;
    int col = 0;
    exp_ovf = 1'b0;
    ent = '{'h038, 'h00C, 'h001, 'h006};
    foreach (m[i]) begin
      if (m[i] == 8'h0A) begin
        if (!line2) ent.push_back('h0C0);
        line2 = 1'b1;
        col = 0;
      end else if (WRAP && line2 && col == LINE_LEN) begin
        exp_ovf = 1'b1;
      end else begin
        if (WRAP && col == LINE_LEN) begin
          ent.push_back('h0C0);
          line2 = 1'b1;
          col = 0;
        end
        ent.push_back('h100 + int'(m[i]));
        col++;
      end
    end
    if (ent.size() > DEPTH - 1) begin
      exp_ovf = 1'b1;
      ent = ent[0:DEPTH-2];
    end
    ent.push_back(0);
    exp_d = ent;
  endfunction

  task automatic run_msg(input string name, input bq_t m, input int gap_pct, input int exp_stalls);
    int base, done0, idx, budget, stalls, wait0, n;
    bit acc_any;
    base = got.size();
    done0 = done_cnt;
    model(m);
    idx = 0; budget = 0; stalls = 0; wait0 = 0; acc_any = 1'b0;
    while (idx < m.size() && budget < 4000) begin
      @(negedge clk);
      budget++;
      if (gap_pct != 0 && $urandom_range(0, 99) < gap_pct) begin
        bus.in_valid = 1'b0;
      end else begin
        bus.in_valid = 1'b1;
        bus.in_data  = m[idx];
        bus.in_last  = (idx == m.size() - 1);
      end
      if (bus.in_valid) begin
        if (bus.in_ready) begin
          idx++;
          acc_any = 1'b1;
        end else if (acc_any) stalls++;
        else wait0++;
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    chk({name, " accepted"}, idx, m.size());
    while (done_cnt == done0 && budget < 6000) begin
      @(negedge clk);
      budget++;
    end
    chk({name, " msg_done"}, done_cnt - done0, 1);
    chk({name, " overflow"}, int'(bus.overflow), int'(exp_ovf));
    chk({name, " n_writes"}, got.size() - base, exp_d.size());
    n = got.size() - base;
    if (n > exp_d.size()) n = exp_d.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s w%0d addr", name, i), got[base+i].a, i);
      chk($sformatf("%s w%0d data", name, i), got[base+i].d, exp_d[i]);
    end
    if (got.size() > base) chk({name, " done_lag"}, done_cyc - got[got.size()-1].c, 1);
    if (exp_stalls >= 0) chk({name, " stalls"}, stalls, exp_stalls);
    if (gap_pct == 0) chk({name, " first_accept_wait"}, wait0, 5);
    if (gap_pct == 0 && m.size() == 1 && got.size() > base)
      chk({name, " latency"}, done_cyc - got[base].c, 6);
  endtask

  vec_t vt[8];
  int   hi_exp[7] = '{'h038, 'h00C, 'h001, 'h006, 'h148, 'h149, 'h000};

  initial begin
    int   base, idx, budget, len, gap;
    bq_t  m;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;

    vt[0] = '{"hi",       "HI",            6,                0,            0};
    vt[1] = '{"newlines", "A\nB\nC",       8,                0,            0};
    vt[2] = '{"x20",      rep("x", 20),    WRAP ? 25 : 24,   0,            WRAP ? 1 : 0};
    vt[3] = '{"a70",      rep("a", 70),    WRAP ? 37 : 63,   1,            WRAP ? 1 : 0};
    vt[4] = '{"b59",      rep("b", 59),    WRAP ? 37 : 63,   WRAP ? 1 : 0, WRAP ? 1 : 0};
    vt[5] = '{"b60",      rep("b", 60),    WRAP ? 37 : 63,   1,            WRAP ? 1 : 0};
    vt[6] = '{"nl_only",  "\n\n",          5,                0,            0};
    vt[7] = '{"single",   "Z",             5,                0,            0};

    repeat (3) @(negedge clk);
    chk("rst in_ready", int'(bus.in_ready), 0);
    chk("rst wr_en",    int'(bus.wr_en),    0);
    chk("rst wr_addr",  int'(bus.wr_addr),  0);
    chk("rst wr_data",  int'(bus.wr_data),  0);
    chk("rst msg_done", int'(bus.msg_done), 0);
    chk("rst overflow", int'(bus.overflow), 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      base = got.size();
      run_msg(vt[i].name, s2q(vt[i].text), 0, vt[i].stalls);
      chk({vt[i].name, " table_ovf"}, int'(bus.overflow), vt[i].ovf);
      if (got.size() > base) begin
        chk({vt[i].name, " term_addr"}, got[got.size()-1].a, vt[i].term_addr);
        chk({vt[i].name, " term_data"}, got[got.size()-1].d, 0);
      end else chk({vt[i].name, " term_addr"}, -1, vt[i].term_addr);
    end

    base = got.size();
    run_msg("hi_hand", s2q("HI"), 0, 0);
    for (int j = 0; j < 7; j++) begin
      if (base + j < got.size()) chk($sformatf("hi_hand e%0d", j), got[base+j].d, hi_exp[j]);
      else chk($sformatf("hi_hand e%0d", j), -1, hi_exp[j]);
    end

    // Reset in DATA after three characters have been written.
    base = got.size();
    m = s2q("ABCD");
    idx = 0; budget = 0;
    while (idx < 3 && budget < 100) begin
      @(negedge clk);
      budget++;
      bus.in_valid = 1'b1;
      bus.in_data  = m[idx];
      bus.in_last  = 1'b0;
      if (bus.in_ready) idx++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("midrst writes_before", got.size() - base, 7);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst wr_en",    int'(bus.wr_en),    0);
    chk("midrst in_ready", int'(bus.in_ready), 0);
    chk("midrst wr_addr",  int'(bus.wr_addr),  0);
    chk("midrst overflow", int'(bus.overflow), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst no_writes_after", got.size() - base, 7);
    run_msg("post_rst", s2q("Q"), 0, 0);

    for (int k = 0; k < 12; k++) begin
      m = {};
      len = $urandom_range(1, 80);
      for (int i = 0; i < len; i++)
        m.push_back(($urandom_range(0, 99) < 12) ? 8'h0A : 8'($urandom_range(32, 126)));
      gap = (k % 2 == 1) ? 25 : 0;
      run_msg($sformatf("rnd%0d", k), m, gap, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
